// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default frame width and
// the helper that sizes requester-index fields.
package uart_pkg;

  localparam int UART_BITS = 8;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_LOAD      = 5'b00010,
    ST_START     = 5'b00100,
    ST_WAIT_BUSY = 5'b01000,
    ST_WAIT_DONE = 5'b10000
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_select.sv
// Round-robin pick: first valid requester at or after ptr, wrapping past NUM_REQ-1.
module uart_rr_select
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]           valid,
  input  logic [id_width(NUM_REQ)-1:0] ptr,
  output logic [id_width(NUM_REQ)-1:0] winner,
  output logic                         any_valid
);

  localparam int W = id_width(NUM_REQ);

  logic [W-1:0] idx;

  // Scan from the farthest candidate back toward ptr so the nearest valid one wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    winner    = ptr;
    any_valid = 1'b0;
    idx       = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = W'((int'(ptr) + off) % NUM_REQ);
      if (valid[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-granted sharing of one UART transmitter among NUM_REQ byte streams.
// Optional transmitter-start timeout: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BITS      = UART_BITS,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*BITS-1:0]       req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [BITS-1:0]               tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic [id_width(NUM_REQ)-1:0]  grant_id,
  output logic                          grant_active,
  output logic                          tx_error
);

  localparam int W  = id_width(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  if (NUM_REQ < 2 || MAX_BURST < 1 || TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: needs NUM_REQ>=2, MAX_BURST>=1, TIMEOUT>=1");
  end

  arb_state_e    state;
  logic [W-1:0]  rr_ptr;
  logic [W-1:0]  next_ptr;
  logic [W-1:0]  winner;
  logic          any_valid;
  logic [CW-1:0] burst_cnt;
  logic          last_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timeout_cnt;
`else
  assign tx_error = 1'b0;
`endif

  uart_rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // The owner that just finished moves to the back of the round-robin order.
  assign next_ptr = (grant_id == W'(NUM_REQ - 1)) ? '0 : grant_id + W'(1);

  // Acceptance depends on the owner's valid in the same LOAD cycle, so it is a decode.
  always_comb begin
    req_ready = '0;
    if (state == ST_LOAD && req_valid[grant_id]) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      last_q       <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tx_error     <= 1'b0;
      timeout_cnt  <= '0;
`endif
    end else begin
      // NOTE: sequential state uses <= so every register sees pre-edge values.
      tx_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant_id     <= winner;
            grant_active <= 1'b1;
            burst_cnt    <= '0;
            state        <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (req_valid[grant_id]) begin
            tx_data   <= req_data[int'(grant_id) * BITS +: BITS];
            last_q    <= req_last[grant_id];
            burst_cnt <= burst_cnt + CW'(1);
            tx_start  <= 1'b1;
            state     <= ST_START;
          end else begin
            grant_active <= 1'b0;
            rr_ptr       <= next_ptr;
            state        <= ST_IDLE;
          end
        end
        ST_START: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
          // The START cycle counts as the first cycle of the wait.
          timeout_cnt <= TW'(1);
`endif
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (timeout_cnt >= TW'(TIMEOUT - 1)) begin
            tx_error     <= 1'b1;
            grant_active <= 1'b0;
            rr_ptr       <= next_ptr;
            state        <= ST_IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
          end
`endif
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_q || burst_cnt == CW'(MAX_BURST)) begin
              grant_active <= 1'b0;
              rr_ptr       <= next_ptr;
              state        <= ST_IDLE;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: message-level round-robin model, scoreboard
// of (owner, byte) per tx_start, and a behavioural transmitter with random frame timing.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int BITS      = 8;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 8;
  localparam int W         = id_width(NUM_REQ);

  typedef struct packed {
    logic [BITS-1:0] data;
    logic            last;
  } beat_t;

  typedef struct {
    int              id;
    logic [BITS-1:0] data;
  } sent_t;

  logic                    clk;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*BITS-1:0] req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      req_ready;
  logic [BITS-1:0]         tx_data;
  logic                    tx_start;
  logic                    tx_busy;
  logic [W-1:0]            grant_id;
  logic                    grant_active;
  logic                    tx_error;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t req_q[NUM_REQ][$];
  sent_t exp_q[$];
  int    model_ptr = 0;

  int  cyc   = 0;
  int  epoch = 0;
  bit  xmit_en = 1'b1;
  logic [NUM_REQ-1:0] accepted = '0;
  int  rise_cyc = -1, ready_cyc = -1, start_cyc = -1;
  int  last_start_cyc = -1, err_cyc = -1;
  logic err_grant = 1'b0;
  int  n_start = 0;
  int  n_ready[NUM_REQ] = '{default: 0};
  logic prev_start = 1'b0;
  sent_t mon_e;
  logic [BITS-1:0] tx_cap;
  int  tx_ep;

  uart_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .BITS      (BITS),
    .MAX_BURST (MAX_BURST),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .tx_error     (tx_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id, input logic [BITS-1:0] d, input logic last);
    req_q[id].push_back('{data: d, last: last});
  endtask

  task automatic drive_reqs();
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_q[i].size() > 0) begin
        v[i]                   = 1'b1;
        req_data[i*BITS +: BITS] = req_q[i][0].data;
        req_last[i]            = req_q[i][0].last;
      end else begin
        req_data[i*BITS +: BITS] = '0;
        req_last[i]            = 1'b0;
      end
    end
    if (req_valid == '0 && v != '0 && rise_cyc < 0) rise_cyc = cyc;
    req_valid = v;
  endtask

  // Requester side: pop a byte after its acceptance edge, then present the next one.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (accepted[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
      accepted = '0;
      drive_reqs();
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        accepted = req_ready;
        if (req_ready != '0) begin
          check("ready_onehot", 32'($onehot(req_ready)), 1);
          check("ready_owner", 32'(req_ready), 32'(1) << grant_id);
          check("ready_active", 32'(grant_active), 1);
          for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) n_ready[i]++;
          if (ready_cyc < 0 && rise_cyc >= 0) ready_cyc = cyc;
        end
        if (tx_start) begin
          n_start++;
          last_start_cyc = cyc;
          if (start_cyc < 0 && rise_cyc >= 0) start_cyc = cyc;
          check("start_pulse", 32'(prev_start), 0);
          check("start_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("start_owner", 32'(grant_id), mon_e.id);
            check("start_data", 32'(tx_data), 32'(mon_e.data));
          end
        end
        if (tx_error && err_cyc < 0) begin
          err_cyc   = cyc;
          err_grant = grant_active;
        end
      end
      prev_start = tx_start;
    end
  end

  // Transmitter: busy rises 1..4 cycles after tx_start and lasts 2..6 cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && tx_start && xmit_en) begin
        tx_cap = tx_data;
        tx_ep  = epoch;
        repeat ($urandom_range(0, 3) + 1) @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1 tx_busy = 1'b0;
        if (tx_ep == epoch) check("tx_data_hold", 32'(tx_data), 32'(tx_cap));
      end
    end
  end

  // Message-level model: bursts end on last, on MAX_BURST bytes, or when the owner runs dry.
  task automatic model_round();
    beat_t mq[NUM_REQ][$];
    int    id;
    int    n;
    bit    more;
    beat_t b;
    for (int i = 0; i < NUM_REQ; i++) mq[i] = req_q[i];
    more = 1'b1;
    while (more) begin
      id = -1;
      for (int k = NUM_REQ - 1; k >= 0; k--)
        if (mq[(model_ptr + k) % NUM_REQ].size() > 0) id = (model_ptr + k) % NUM_REQ;
      if (id < 0) begin
        more = 1'b0;
      end else begin
        n = 0;
        do begin
          b = mq[id].pop_front();
          exp_q.push_back('{id: id, data: b.data});
          n++;
        end while (!b.last && n < MAX_BURST && mq[id].size() > 0);
        model_ptr = (id + 1) % NUM_REQ;
      end
    end
  endtask

  task automatic start_round();
    rise_cyc  = -1;
    ready_cyc = -1;
    start_cyc = -1;
    model_round();
  endtask

  task automatic finish_round(input string tag);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && !tx_busy && !grant_active;
      for (int i = 0; i < NUM_REQ; i++) if (req_q[i].size() > 0) done = 1'b0;
    end
    check({tag, "_done"}, 32'(done), 1);
    if (rise_cyc >= 0) begin
      check({tag, "_lat_ready"}, ready_cyc - rise_cyc, 1);
      check({tag, "_lat_start"}, start_cyc - rise_cyc, 2);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic random_round();
    bit any;
    int nmsg;
    int len;
    any = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        any  = 1'b1;
        nmsg = $urandom_range(1, 3);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++)
            push(i, BITS'($urandom),
                 (b == len - 1) && !(m == nmsg - 1 && $urandom_range(0, 4) == 0));
        end
      end
    end
    if (!any) push($urandom_range(0, NUM_REQ - 1), BITS'($urandom), 1'b1);
    start_round();
    finish_round("random");
  endtask

  initial begin
    int s0;
    int r0;
    int n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_start", 32'(tx_start), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_active", 32'(grant_active), 0);
    check("rst_error", 32'(tx_error), 0);
    rst = 1'b1;

    // Contention from pointer 0, then 0 and 1 again with the pointer back at 0.
    @(negedge clk);
    push(0, 8'hA0, 1'b1);
    push(1, 8'hA1, 1'b1);
    push(3, 8'hA3, 1'b1);
    start_round();
    finish_round("contend");
    @(negedge clk);
    push(0, 8'hB0, 1'b1);
    push(1, 8'hB1, 1'b1);
    start_round();
    finish_round("rerequest");

    // Single two-byte message from requester 2.
    @(negedge clk);
    s0 = n_start;
    r0 = n_ready[2];
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b1);
    start_round();
    finish_round("single");
    check("single_starts", n_start - s0, 2);
    check("single_readies", n_ready[2] - r0, 2);
    check("single_released", 32'(grant_active), 0);

    // Burst cap: requester 1 streams 10 bytes without last while requester 2 waits.
    @(negedge clk);
    for (int b = 0; b < 10; b++) push(1, BITS'(8'h10 + b), 1'b0);
    push(2, 8'h20, 1'b0);
    push(2, 8'h21, 1'b1);
    start_round();
    finish_round("burst_cap");

    for (int r = 0; r < 12; r++) random_round();

`ifdef UART_TX_ARB_TIMEOUT_EN
    xmit_en = 1'b0;
    @(negedge clk);
    push(1, 8'h77, 1'b1);
    start_round();
    finish_round("timeout");
    check("timeout_latency", err_cyc - last_start_cyc, TIMEOUT);
    check("timeout_release", 32'(err_grant), 0);
    check("timeout_flag", 32'(tx_error), 1);
    xmit_en = 1'b1;
    @(negedge clk);
    push(2, 8'h78, 1'b1);
    start_round();
    finish_round("after_timeout");
    check("error_sticky", 32'(tx_error), 1);
`endif

    // Asynchronous reset while the transmitter is mid-frame.
    @(negedge clk);
    push(2, 8'h51, 1'b0);
    push(2, 8'h52, 1'b0);
    push(2, 8'h53, 1'b1);
    start_round();
    n = 0;
    while (!(grant_active && tx_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_wait_done", 32'(grant_active && tx_busy), 1);
    #2 rst = 1'b0;
    epoch++;
    #1;
    check("arst_ready", 32'(req_ready), 0);
    check("arst_start", 32'(tx_start), 0);
    check("arst_data", 32'(tx_data), 0);
    check("arst_grant_id", 32'(grant_id), 0);
    check("arst_active", 32'(grant_active), 0);
    check("arst_error", 32'(tx_error), 0);
    for (int i = 0; i < NUM_REQ; i++) req_q[i].delete();
    exp_q.delete();
    model_ptr = 0;
    n = 0;
    while (tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Owner drops valid after one byte without last: released with no start, then 3.
    @(negedge clk);
    s0 = n_start;
    push(0, 8'hD0, 1'b0);
    push(3, 8'hD3, 1'b1);
    start_round();
    finish_round("drop");
    check("drop_starts", n_start - s0, 2);

    random_round();
`ifndef UART_TX_ARB_TIMEOUT_EN
    check("error_tied_low", 32'(tx_error), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
